pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised, elastic pipeline-stage register for the CPU datapath (EX/MEM, MEM/WB and later stages).
- Carries an opaque payload of DATA_W bits using a valid/ready handshake on each side.
- Holds up to two entries (main + skid) so in_ready_o is a registered signal, and the stage sustains full throughput under downstream backpressure.
- Adds a global freeze (stall_i), a synchronous flush (flush_i) and occupancy reporting.

Parameters:
- DATA_W, 77, payload width (EX/MEM: alu_result 32 + rs2_data 32 + rs2 5 + rsd 5 + Op 3).
- CLEAR_DATA, 1, when 1, flush and reset zero the payload registers; when 0, only the valid bits are cleared.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- stall_i  in  1  global freeze; no state change while high, except flush.
- flush_i  in  1  synchronous flush; discards every held entry.
- in_valid_i  in  1  upstream has a payload.
- in_ready_o  out  1  stage can take a payload; registered.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  out_data_o holds a live entry.
- out_ready_i  in  1  downstream can take the payload.
- out_data_o  out  DATA_W  oldest held payload (main register).
- occupancy_o  out  2  number of held entries, 0..2.

Behaviour:
- Single clock edge: all registers update on posedge clk_i only. No negedge stage.
- Reset (rst_i=0, asynchronous): state EMPTY; out_valid_o=0; occupancy_o=0; in_ready_o=1; out_data_o=0 and skid register 0 (regardless of CLEAR_DATA).
- Transfer events, evaluated each rising edge:
  - accept = in_valid_i & in_ready_o & ~stall_i
  - emit = out_valid_o & out_ready_i & ~stall_i
  - Upstream and downstream use the same qualified definitions; a handshake while stall_i=1 is not a transfer.
- Outputs as a function of state:
  - in_ready_o = (state != FULL)
  - out_valid_o = (state != EMPTY)
  - occupancy_o: EMPTY=0, ONE=1, FULL=2
- State machine, priority flush > stall > normal:
  - EMPTY: accept -> ONE, main <= in_data_i.
  - ONE: accept&emit -> ONE, main <= in_data_i. accept&~emit -> FULL, skid <= in_data_i. ~accept&emit -> EMPTY. Neither -> hold.
  - FULL: emit -> ONE, main <= skid. accept cannot occur. Otherwise hold.
  - flush_i=1 from any state, even with stall_i=1 -> EMPTY next edge.
    - An in-flight accept that cycle is dropped.
    - An emit that cycle still counts for downstream, since it sampled the old main.
    - If CLEAR_DATA=1, main and skid are zeroed.
  - stall_i=1 with flush_i=0: every register holds; outputs are unchanged apart from the combinational qualification above.
- Latency: a payload accepted at edge N appears on out_data_o with out_valid_o=1 after edge N (1 cycle) if the stage was EMPTY, or if it was ONE with emit.
- Ordering: strict FIFO; the skid entry never bypasses the main entry.
- Throughput: 1 payload/cycle when out_ready_i=1 continuously.
- Payload stability: out_data_o does not change while out_valid_o=1 and no emit (AXI-style stability).
- Reset mid-operation: all entries are lost immediately (asynchronous); the first accept is possible on the first rising edge after rst_i rises.
- Width: no arithmetic; the payload passes through bit-exact, with no truncation or extension.

Decomposition:
- Shared package pipe_pkg:
  - State encoding localparams: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
  - Payload field-width constants: ALU_W=32, REG_IDX_W=5, OP_W=3.
  - Derived EX_MEM_W=77 and MEM_WB_W.
- Packing and unpacking of payload fields is done by the instantiating stage wrapper, not by this block.
- No sub-module: a single flat module (main reg, skid reg, 2-bit state).

Test Plan:
- Reset: hold rst_i=0 with in_valid_i=1 -> in_ready_o=1, out_valid_o=0, occupancy_o=0, out_data_o=0; release -> first accept on the next edge.
- Streaming: out_ready_i=1, send 0x1,0x2,0x3 on consecutive cycles -> outputs 0x1,0x2,0x3 one cycle later, back-to-back, occupancy_o stays 1.
- Backpressure: out_ready_i=0, send 0xA,0xB -> occupancy_o=2, in_ready_o=0, out_data_o=0xA held; raise out_ready_i -> 0xA then 0xB, in_ready_o=1 again after the first emit.
- Stall: FULL with 0xA,0xB, stall_i=1 for 3 cycles with out_ready_i=1 and in_valid_i=1 -> no change (occupancy_o=2, out_data_o=0xA); drop stall_i -> normal drain.
- Flush: FULL, flush_i=1 together with stall_i=1 and in_valid_i=1 (0xC) -> next cycle occupancy_o=0, out_valid_o=0, out_data_o=0 (CLEAR_DATA=1); 0xC is never emitted.
- Async reset mid-stream: assert rst_i between edges while ONE -> out_valid_o drops without a clock edge; payload lost.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and payload widths for pipeline stage registers
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam int ALU_W     = 32;
  localparam int REG_IDX_W = 5;
  localparam int OP_W      = 3;

  // EX/MEM: alu_result + rs2_data + rs2 + rsd + op; MEM/WB: alu_result + mem_data + rsd + op
  localparam int EX_MEM_W = ALU_W + ALU_W + REG_IDX_W + REG_IDX_W + OP_W;
  localparam int MEM_WB_W = ALU_W + ALU_W + REG_IDX_W + OP_W;

endpackage

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry elastic pipeline register with stall, flush and occupancy
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W     = EX_MEM_W,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  stage_state_e      state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              accept;
  logic              emit;

  // Handshake outputs decode straight from the state register, so in_ready_o never depends on out_ready_i.
  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;

  always_comb begin
    occupancy_o = 2'd0;
    case (state_q)
      ONE:     occupancy_o = 2'd1;
      FULL:    occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  assign accept = in_valid_i & in_ready_o & ~stall_i;
  assign emit   = out_valid_o & out_ready_i & ~stall_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
      if (CLEAR_DATA) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else if (!stall_i) begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= ONE;
            main_q  <= in_data_i;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_q <= in_data_i;
          end else if (accept) begin
            state_q <= FULL;
            skid_q  <= in_data_i;
          end else if (emit) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          // Skid entry is younger, so it only ever moves into main; it never bypasses it.
          if (emit) begin
            state_q <= ONE;
            main_q  <= skid_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - directed self-checking bench for pipe_skid_stage
module tb_pipe_skid_stage;

  localparam int W = 77;

  logic         clk_i;
  logic         rst_i;
  logic         stall_i;
  logic         flush_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] in_data_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] out_data_o;
  logic [1:0]   occupancy_o;

  int checks;
  int failures;

  pipe_skid_stage #(.DATA_W(W), .CLEAR_DATA(1'b1)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .occupancy_o (occupancy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [1:0] occ, input logic ov,
                              input logic ir, input logic [W-1:0] data);
    check({tag, "_occ"}, W'(occupancy_o), W'(occ));
    check({tag, "_out_valid"}, W'(out_valid_o), W'(ov));
    check({tag, "_in_ready"}, W'(in_ready_o), W'(ir));
    check({tag, "_out_data"}, out_data_o, data);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_i       = 1'b0;
    stall_i     = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = W'(77'h55);
    out_ready_i = 1'b0;

    #12;
    expect_state("reset", 2'd0, 1'b0, 1'b1, '0);
    rst_i = 1'b1;
    step();
    expect_state("first_accept", 2'd1, 1'b1, 1'b1, W'(77'h55));

    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    expect_state("drain0", 2'd0, 1'b0, 1'b1, W'(77'h55));

    // Streaming: one payload per cycle, occupancy stays at one.
    in_valid_i = 1'b1;
    in_data_i  = W'(77'h1);
    step();
    expect_state("stream1", 2'd1, 1'b1, 1'b1, W'(77'h1));
    in_data_i = W'(77'h2);
    step();
    expect_state("stream2", 2'd1, 1'b1, 1'b1, W'(77'h2));
    in_data_i = W'(77'h3);
    step();
    expect_state("stream3", 2'd1, 1'b1, 1'b1, W'(77'h3));
    in_valid_i = 1'b0;
    step();
    expect_state("stream_end", 2'd0, 1'b0, 1'b1, W'(77'h3));

    // Backpressure fills the skid entry.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = W'(77'hA);
    step();
    expect_state("bp_one", 2'd1, 1'b1, 1'b1, W'(77'hA));
    in_data_i = W'(77'hB);
    step();
    expect_state("bp_full", 2'd2, 1'b1, 1'b0, W'(77'hA));
    in_data_i = W'(77'hD);
    step();
    expect_state("bp_full_hold", 2'd2, 1'b1, 1'b0, W'(77'hA));
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    expect_state("bp_emit_a", 2'd1, 1'b1, 1'b1, W'(77'hB));
    step();
    expect_state("bp_emit_b", 2'd0, 1'b0, 1'b1, W'(77'hB));

    // Stall while FULL with both handshakes offered.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = W'(77'hA);
    step();
    in_data_i = W'(77'hB);
    step();
    stall_i     = 1'b1;
    out_ready_i = 1'b1;
    in_data_i   = W'(77'hE);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_state($sformatf("stall%0d", i), 2'd2, 1'b1, 1'b0, W'(77'hA));
    end
    stall_i    = 1'b0;
    in_valid_i = 1'b0;
    step();
    expect_state("stall_drain_a", 2'd1, 1'b1, 1'b1, W'(77'hB));
    step();
    expect_state("stall_drain_b", 2'd0, 1'b0, 1'b1, W'(77'hB));

    // Flush wins over stall and drops the concurrent input.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = W'(77'hA);
    step();
    in_data_i = W'(77'hB);
    step();
    expect_state("pre_flush", 2'd2, 1'b1, 1'b0, W'(77'hA));
    flush_i     = 1'b1;
    stall_i     = 1'b1;
    out_ready_i = 1'b1;
    in_data_i   = W'(77'hC);
    step();
    expect_state("flush", 2'd0, 1'b0, 1'b1, '0);
    flush_i    = 1'b0;
    stall_i    = 1'b0;
    in_valid_i = 1'b0;
    step();
    expect_state("flush_after", 2'd0, 1'b0, 1'b1, '0);

    // Wide payload passes bit-exact.
    in_valid_i  = 1'b1;
    out_ready_i = 1'b0;
    in_data_i   = {13'h1ABC, 64'hDEAD_BEEF_CAFE_F00D};
    step();
    expect_state("wide", 2'd1, 1'b1, 1'b1, {13'h1ABC, 64'hDEAD_BEEF_CAFE_F00D});

    // Asynchronous reset between edges.
    in_valid_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    expect_state("async_reset", 2'd0, 1'b0, 1'b1, '0);
    rst_i      = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = W'(77'h99);
    step();
    expect_state("post_reset_accept", 2'd1, 1'b1, 1'b1, W'(77'h99));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
